// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array slice: default geometry, drain FSM states,
// and the flat PE-bus slice offset used by the array top, operand feeder and result drain.
package systolic_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

    function automatic int pe_offset(input int r, input int c, input int n, input int data_w);
        return (r * n + c) * data_w;
    endfunction

endpackage

// File: rtl/systolic_result_drain_ctr.sv
// Row-major drain index for an NxN buffer; row/col are stepped alongside idx so no divide is needed.
// idx saturates at N*N-1 so it can never wrap back onto element (0,0).
module drain_index_ctr #(
    parameter int N = systolic_pkg::N
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_advance,
    output logic [$clog2(N*N)-1:0]    o_idx,
    output logic [$clog2(N)-1:0]      o_row,
    output logic [$clog2(N)-1:0]      o_col,
    output logic                      o_last
);

    localparam int IDX_W = $clog2(N*N);
    localparam int RC_W  = $clog2(N);

    logic [IDX_W-1:0] r_idx;
    logic [RC_W-1:0]  r_row;
    logic [RC_W-1:0]  r_col;
    logic             w_last;

    assign w_last = (r_idx == IDX_W'(N*N-1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance && !w_last) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == RC_W'(N-1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the NxN PE result bus on start and streams it row-major over valid/ready.
// state | meaning: IDLE | waiting for start; STREAM | presenting buf[idx]; DONE | one-cycle completion pulse
module systolic_result_drain #(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [N*N*DATA_W-1:0]    i_results_in,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(N)-1:0]     o_out_row,
    output logic [$clog2(N)-1:0]     o_out_col,
    output logic                     o_out_last,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overrun
);

    import systolic_pkg::*;

    localparam int IDX_W = $clog2(N*N);
    localparam int RC_W  = $clog2(N);

    drain_state_t     r_state;
    drain_state_t     w_state_nxt;
    logic [DATA_W-1:0] r_buf [N*N];
    logic             r_overrun;

    logic [IDX_W-1:0] w_idx;
    logic [RC_W-1:0]  w_row;
    logic [RC_W-1:0]  w_col;
    logic             w_last;
    logic             w_capture;
    logic             w_accept;
    logic             w_advance;

    assign w_capture = (r_state == IDLE) && i_start;
    assign w_accept  = (r_state == STREAM) && i_out_ready;
    assign w_advance = w_accept && !w_last;

    drain_index_ctr #(
        .N (N)
    ) u_idx (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_capture),
        .i_advance (w_advance),
        .o_idx     (w_idx),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_row   = '0;
        o_out_col   = '0;
        o_out_last  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                o_out_valid = 1'b1;
                o_out_data  = r_buf[w_idx];
                o_out_row   = w_row;
                o_out_col   = w_col;
                o_out_last  = w_last;
                o_busy      = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // results_in is only looked at on the capture edge; the buffer is frozen otherwise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N*N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_buf[r*N+c] <= i_results_in[pe_offset(r, c, N, DATA_W) +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_start && (r_state != IDLE);
        end
    end

    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomised bench for the result drain: N=2 and N=4 instances checked against a row-major queue model.
module tb_systolic_result_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start2;
    logic [31:0] bus2;
    logic        ready2;
    logic [7:0]  data2;
    logic        valid2;
    logic [0:0]  row2;
    logic [0:0]  col2;
    logic        last2, busy2, done2, ovr2;

    logic         start4;
    logic [127:0] bus4;
    logic         ready4;
    logic [7:0]   data4;
    logic         valid4;
    logic [1:0]   row4;
    logic [1:0]   col4;
    logic         last4, busy4, done4, ovr4;

    int checks = 0;
    int errors = 0;

    systolic_result_drain #(.N(2), .DATA_W(8)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start2), .i_results_in(bus2),
        .o_out_data(data2), .o_out_valid(valid2), .i_out_ready(ready2),
        .o_out_row(row2), .o_out_col(col2), .o_out_last(last2),
        .o_busy(busy2), .o_done(done2), .o_overrun(ovr2)
    );

    systolic_result_drain #(.N(4), .DATA_W(8)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_start(start4), .i_results_in(bus4),
        .o_out_data(data4), .o_out_valid(valid4), .i_out_ready(ready4),
        .o_out_row(row4), .o_out_col(col4), .o_out_last(last4),
        .o_busy(busy4), .o_done(done4), .o_overrun(ovr4)
    );

    task automatic test_reset();
        rst = 1'b1; start2 = 1'b0; bus2 = '0; ready2 = 1'b0;
        start4 = 1'b0; bus4 = '0; ready4 = 1'b0;
        #2;
        checks++;
        if (valid2 !== 1'b0 || data2 !== 8'h00 || row2 !== 1'b0 || col2 !== 1'b0 || last2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out2 valid=%b data=%h row=%b col=%b last=%b expected all zero", valid2, data2, row2, col2, last2);
        end
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || ovr2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags2 busy=%b done=%b overrun=%b expected 0 0 0", busy2, done2, ovr2);
        end
        checks++;
        if (valid4 !== 1'b0 || data4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0 || ovr4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n4 valid=%b data=%h busy=%b done=%b overrun=%b expected zero", valid4, data4, busy4, done4, ovr4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_start2(input logic [31:0] bus);
        bus2 = bus;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    // mode 0: ready always 1; 1: random ready; 2: fixed pattern 0,0,1,0,1,1,0,1
    task automatic stream2(input int mode, input logic [31:0] exp, input int ovr_at,
                           input logic [31:0] alt, input bit scramble, input bit done_start);
        int k = 0;
        int cyc = 0;
        int ovr_cnt = 0;
        int exp_ovr;
        bit r;
        int pat[8] = '{0, 0, 1, 0, 1, 1, 0, 1};
        logic [7:0] q[$];
        for (int i = 0; i < 4; i++) q.push_back(exp[i*8 +: 8]);
        exp_ovr = (ovr_at >= 0 ? 1 : 0) + (done_start ? 1 : 0);
        while (k < 4 && cyc < 64) begin
            checks++;
            if (valid2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL stream2_ctl k=%0d valid=%b busy=%b done=%b expected 1 1 0", k, valid2, busy2, done2);
            end
            checks++;
            if (data2 !== q[k] || row2 !== 1'(k / 2) || col2 !== 1'(k % 2) || last2 !== (k == 3)) begin
                errors++;
                $display("FAIL stream2_data k=%0d got data=%h row=%0d col=%0d last=%b expected %h %0d %0d %b",
                         k, data2, row2, col2, last2, q[k], k / 2, k % 2, (k == 3));
            end
            if (ovr2 === 1'b1) ovr_cnt++;
            r = (mode == 0) ? 1'b1 : (mode == 2) ? 1'(pat[cyc % 8]) : 1'($urandom_range(0, 1));
            ready2 = r;
            if (cyc == ovr_at) begin
                start2 = 1'b1;
                bus2 = alt;
            end
            if (scramble && cyc == 0) bus2 = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            start2 = 1'b0;
            if (r) k++;
            cyc++;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL stream2_timeout accepted=%0d expected 4", k);
        end
        if (ovr2 === 1'b1) ovr_cnt++;
        checks++;
        if (done2 !== 1'b1 || valid2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL stream2_done done=%b valid=%b busy=%b expected 1 0 0", done2, valid2, busy2);
        end
        if (mode != 1) begin
            checks++;
            if (cyc != ((mode == 0) ? 4 : 8)) begin
                errors++;
                $display("FAIL stream2_cycles got %0d expected %0d", cyc, (mode == 0) ? 4 : 8);
            end
        end
        ready2 = 1'b0;
        if (done_start) begin
            start2 = 1'b1;
            bus2 = alt;
        end
        @(posedge clk); #1;
        start2 = 1'b0;
        if (ovr2 === 1'b1) ovr_cnt++;
        checks++;
        if (done2 !== 1'b0 || valid2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL stream2_idle done=%b valid=%b busy=%b expected 0 0 0", done2, valid2, busy2);
        end
        checks++;
        if (ovr_cnt != exp_ovr) begin
            errors++;
            $display("FAIL stream2_overrun pulses=%0d expected %0d", ovr_cnt, exp_ovr);
        end
    endtask

    task automatic stream4(input int mode, input logic [127:0] exp);
        int k = 0;
        int s = 1;
        bit r;
        bus4 = exp;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        while (k < 16 && s < 200) begin
            checks++;
            if (valid4 !== 1'b1 || data4 !== exp[k*8 +: 8] || row4 !== 2'(k / 4) || col4 !== 2'(k % 4)
                || last4 !== (k == 15) || done4 !== 1'b0) begin
                errors++;
                $display("FAIL stream4_elem k=%0d valid=%b data=%h row=%0d col=%0d last=%b expected 1 %h %0d %0d %b",
                         k, valid4, data4, row4, col4, last4, exp[k*8 +: 8], k / 4, k % 4, (k == 15));
            end
            r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ready4 = r;
            if (r == 1'b0) bus4 = 128'($urandom) ^ exp;
            @(posedge clk); #1;
            s++;
            if (r) k++;
        end
        ready4 = 1'b0;
        checks++;
        if (done4 !== 1'b1 || valid4 !== 1'b0 || busy4 !== 1'b0 || k != 16) begin
            errors++;
            $display("FAIL stream4_done done=%b valid=%b busy=%b accepted=%0d expected 1 0 0 16", done4, valid4, busy4, k);
        end
        if (mode == 0) begin
            checks++;
            if (s != 17) begin
                errors++;
                $display("FAIL stream4_latency done at cycle %0d expected 17", s);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL stream4_done_width done=%b expected 0", done4);
        end
    endtask

    task automatic test_basic();
        do_start2(32'h4433_2211);
        stream2(0, 32'h4433_2211, -1, '0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_start2(32'h4433_2211);
        stream2(2, 32'h4433_2211, -1, '0, 1'b0, 1'b0);
    endtask

    task automatic test_input_change();
        do_start2(32'h4433_2211);
        stream2(0, 32'h4433_2211, -1, '0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        do_start2(32'h4433_2211);
        stream2(0, 32'h4433_2211, 1, 32'hAAAA_AAAA, 1'b0, 1'b0);
        do_start2(32'hAAAA_AAAA);
        stream2(1, 32'hAAAA_AAAA, -1, '0, 1'b0, 1'b1);
    endtask

    task automatic test_idle_ready();
        ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (valid2 !== 1'b0 || done2 !== 1'b0 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready valid=%b done=%b busy=%b expected 0 0 0", valid2, done2, busy2);
            end
        end
        ready2 = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] fresh;
        do_start2($urandom);
        ready2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready2 = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (valid2 !== 1'b0 || busy2 !== 1'b0 || data2 !== 8'h00 || row2 !== 1'b0 || col2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%b busy=%b data=%h row=%b col=%b expected zero", valid2, busy2, data2, row2, col2);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done2 !== 1'b0 || valid2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done done=%b valid=%b expected 0 0", done2, valid2);
            end
        end
        fresh = $urandom;
        do_start2(fresh);
        stream2(1, fresh, -1, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random2();
        logic [31:0] v;
        logic [31:0] alt;
        for (int it = 0; it < 6; it++) begin
            v = $urandom;
            alt = $urandom;
            do_start2(v);
            stream2(1, v, (it % 2 == 0) ? int'($urandom_range(0, 2)) : -1, alt, 1'(it % 3 == 0), 1'b0);
        end
    endtask

    task automatic test_n4();
        logic [127:0] seq;
        logic [127:0] rnd;
        for (int i = 0; i < 16; i++) seq[i*8 +: 8] = 8'(i);
        stream4(0, seq);
        for (int i = 0; i < 4; i++) rnd[i*32 +: 32] = $urandom;
        stream4(1, rnd);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_input_change();
        test_overrun();
        test_idle_ready();
        test_reset_mid_stream();
        test_random2();
        test_n4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
